// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: MIPS load/store opcodes, access-size codes and decode helpers.
// Pure declarations; no timing of its own.
// No flow control here; callers own all sequencing.
package mem_stage_pkg;

  // MIPS I load/store primary opcodes
  localparam logic [5:0] OPCODE_LB  = 6'b100000;
  localparam logic [5:0] OPCODE_LH  = 6'b100001;
  localparam logic [5:0] OPCODE_LW  = 6'b100011;
  localparam logic [5:0] OPCODE_LBU = 6'b100100;
  localparam logic [5:0] OPCODE_LHU = 6'b100101;
  localparam logic [5:0] OPCODE_SB  = 6'b101000;
  localparam logic [5:0] OPCODE_SH  = 6'b101001;
  localparam logic [5:0] OPCODE_SW  = 6'b101011;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_e;

  // MEM/WB pipeline register contents
  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  write_register;
    logic        reg_write;
    logic        mem_to_reg;
    logic        misaligned;
    logic        load;
    logic [5:0]  opcode;
    logic [1:0]  lane;
  } memwb_t;

  // Access size implied by the opcode; anything unrecognised is treated as a word.
  function automatic mem_size_e mem_size(input logic [5:0] op);
    mem_size_e sz;
    case (op)
      OPCODE_LB, OPCODE_LBU, OPCODE_SB: sz = MEM_SIZE_BYTE;
      OPCODE_LH, OPCODE_LHU, OPCODE_SH: sz = MEM_SIZE_HALF;
      default:                          sz = MEM_SIZE_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OPCODE_LB) || (op == OPCODE_LH) || (op == OPCODE_LW) ||
           (op == OPCODE_LBU) || (op == OPCODE_LHU);
  endfunction

  // Only half and word accesses can fault; every other opcode is always aligned.
  function automatic logic access_misaligned(input logic [5:0] op, input logic [1:0] lane);
    logic mis;
    case (op)
      OPCODE_LH, OPCODE_LHU, OPCODE_SH: mis = lane[0];
      OPCODE_LW, OPCODE_SW:             mis = (lane != 2'b00);
      default:                          mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte-lane enables for a store of the given size at the given lane.
  function automatic logic [3:0] byte_enable(input mem_size_e sz, input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      MEM_SIZE_BYTE: be = 4'b0001 << lane;
      MEM_SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] store_data(input mem_size_e sz, input logic [31:0] rt);
    logic [31:0] d;
    case (sz)
      MEM_SIZE_BYTE: d = {4{rt[7:0]}};
      MEM_SIZE_HALF: d = {2{rt[15:0]}};
      default:       d = rt;
    endcase
    return d;
  endfunction

  // Pick the addressed byte/half out of a little-endian RAM word and extend it.
  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [15:0] half;
    logic [31:0] res;
    sh   = word >> {lane, 3'b000};
    half = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OPCODE_LB:  res = {{24{sh[7]}}, sh[7:0]};
      OPCODE_LBU: res = {24'h0, sh[7:0]};
      OPCODE_LH:  res = {{16{half[15]}}, half};
      OPCODE_LHU: res = {16'h0, half};
      OPCODE_LW:  res = word;
      default:    res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_data_ram.sv
// Data RAM: 2**ADDR_W x 32 words, byte-enabled sync write, sync read port A plus debug port B.
// Latency 1 on both read ports; both return the pre-write word on a same-cycle collision.
// No backpressure; port A read is frozen by rd_en_a_i, port B always reads.
module mem_data_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic              rd_en_a_i,
  input  logic [3:0]        be_a_i,
  input  logic [31:0]       wdata_a_i,
  output logic [31:0]       rdata_a_o,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic [31:0]       rdata_b_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_a_q;
  logic [31:0] rdata_b_q;

  // Byte-lane writes; array contents deliberately survive reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (be_a_i[k]) begin
        mem[addr_a_i][8*k +: 8] <= wdata_a_i[8*k +: 8];
      end
    end
  end

  // Port A read register: read-first, held while the pipeline is frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_q <= 32'h0;
    end else if (rd_en_a_i) begin
      rdata_a_q <= mem[addr_a_i];
    end
  end

  // Port B (debug) read register: free-running, read-old on collision
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_b_q <= 32'h0;
    end else begin
      rdata_b_q <= mem[addr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte/half/word loads and stores on the data RAM, MEM/WB register, debug read.
// Latency 1: EX/MEM inputs at posedge N show on o_* after posedge N; debug read is also 1 cycle.
// No backpressure; i_enable=0 freezes MEM/WB and blocks stores, debug port keeps reading.
import mem_stage_pkg::*;

module mem_stage #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_write_data,
  input  logic [4:0]        i_write_register,
  input  logic              i_reg_write,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_mem_to_reg,
  input  logic [5:0]        i_opcode,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [31:0]       o_read_data,
  output logic [31:0]       o_alu_result,
  output logic [4:0]        o_write_register,
  output logic              o_reg_write,
  output logic              o_mem_to_reg,
  output logic              o_misaligned,
  output logic [31:0]       o_dbg_data
);

  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        lane;
  mem_size_e         size;
  logic              misaligned;
  logic              store_en;
  logic [3:0]        store_be;
  logic [31:0]       store_wdata;
  logic [31:0]       ram_rdata;
  memwb_t            memwb_d;
  memwb_t            memwb_q;

  // Upper address bits are ignored so accesses wrap around the RAM.
  assign word_addr = i_alu_result[ADDR_W+1:2];
  assign lane      = i_alu_result[1:0];
  assign size      = mem_size(i_opcode);
  assign misaligned = access_misaligned(i_opcode, lane);

  // A store on the reset cycle is dropped so a reset cleanly discards the in-flight slot.
  assign store_en    = i_mem_write & i_enable & ~misaligned & ~reset;
  assign store_be    = store_en ? byte_enable(size, lane) : 4'b0000;
  assign store_wdata = store_data(size, i_write_data);

  mem_data_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .addr_a_i  (word_addr),
    .rd_en_a_i (i_enable),
    .be_a_i    (store_be),
    .wdata_a_i (store_wdata),
    .rdata_a_o (ram_rdata),
    .addr_b_i  (i_dbg_addr),
    .rdata_b_o (o_dbg_data)
  );

  // Next MEM/WB contents; a load flagged together with a store never returns data
  always_comb begin
    memwb_d                = '0;
    memwb_d.alu_result     = i_alu_result;
    memwb_d.write_register = i_write_register;
    memwb_d.reg_write      = i_reg_write & ~misaligned;
    memwb_d.mem_to_reg     = i_mem_to_reg;
    memwb_d.misaligned     = misaligned;
    memwb_d.load           = i_mem_read & ~i_mem_write & ~misaligned & is_load_op(i_opcode);
    memwb_d.opcode         = i_opcode;
    memwb_d.lane           = lane;
  end

  // MEM/WB pipeline register: reset beats enable, enable=0 holds
  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_q <= '0;
    end else if (i_enable) begin
      memwb_q <= memwb_d;
    end
  end

  // Lane extraction happens after the register, on the synchronously read RAM word.
  assign o_read_data      = memwb_q.load ? load_extend(memwb_q.opcode, memwb_q.lane, ram_rdata)
                                         : 32'h0;
  assign o_alu_result     = memwb_q.alu_result;
  assign o_write_register = memwb_q.write_register;
  assign o_reg_write      = memwb_q.reg_write;
  assign o_mem_to_reg     = memwb_q.mem_to_reg;
  assign o_misaligned     = memwb_q.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_enable;
  logic [31:0]       i_alu_result;
  logic [31:0]       i_write_data;
  logic [4:0]        i_write_register;
  logic              i_reg_write;
  logic              i_mem_read;
  logic              i_mem_write;
  logic              i_mem_to_reg;
  logic [5:0]        i_opcode;
  logic [ADDR_W-1:0] i_dbg_addr;
  logic [31:0]       o_read_data;
  logic [31:0]       o_alu_result;
  logic [4:0]        o_write_register;
  logic              o_reg_write;
  logic              o_mem_to_reg;
  logic              o_misaligned;
  logic [31:0]       o_dbg_data;

  int total = 0;
  int bad   = 0;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_enable         (i_enable),
    .i_alu_result     (i_alu_result),
    .i_write_data     (i_write_data),
    .i_write_register (i_write_register),
    .i_reg_write      (i_reg_write),
    .i_mem_read       (i_mem_read),
    .i_mem_write      (i_mem_write),
    .i_mem_to_reg     (i_mem_to_reg),
    .i_opcode         (i_opcode),
    .i_dbg_addr       (i_dbg_addr),
    .o_read_data      (o_read_data),
    .o_alu_result     (o_alu_result),
    .o_write_register (o_write_register),
    .o_reg_write      (o_reg_write),
    .o_mem_to_reg     (o_mem_to_reg),
    .o_misaligned     (o_misaligned),
    .o_dbg_data       (o_dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    i_opcode = 6'h00; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_reg_write = 1'b0; i_mem_to_reg = 1'b0; i_alu_result = 32'h0;
    i_write_data = 32'h0; i_write_register = 5'd0;
  endtask

  task automatic store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d);
    nop();
    i_opcode = op; i_mem_write = 1'b1; i_alu_result = addr; i_write_data = d;
  endtask

  task automatic load(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd);
    nop();
    i_opcode = op; i_mem_read = 1'b1; i_alu_result = addr;
    i_reg_write = 1'b1; i_mem_to_reg = 1'b1; i_write_register = rd;
  endtask

  initial begin
    reset = 1'b1; i_enable = 1'b1; i_dbg_addr = '0;
    nop();
    cyc(); cyc();
    chk("rst_rdata", o_read_data, 32'h0);
    chk("rst_alu",   o_alu_result, 32'h0);
    chk("rst_wreg",  {27'h0, o_write_register}, 32'h0);
    chk("rst_flags", {29'h0, o_reg_write, o_mem_to_reg, o_misaligned}, 32'h0);
    chk("rst_dbg",   o_dbg_data, 32'h0);
    reset = 1'b0;

    // 1: SW then LW
    store(OPCODE_SW, 32'h10, 32'hDEADBEEF); cyc();
    chk("sw_mis", {31'h0, o_misaligned}, 32'h0);
    load(OPCODE_LW, 32'h10, 5'd5); cyc();
    chk("lw_data", o_read_data, 32'hDEADBEEF);
    chk("lw_flags", {29'h0, o_reg_write, o_mem_to_reg, o_misaligned}, 32'h6);
    chk("lw_wreg", {27'h0, o_write_register}, 32'd5);
    chk("lw_alu", o_alu_result, 32'h10);

    // 2: byte store into a known word
    store(OPCODE_SW, 32'h20, 32'h11223344); cyc();
    store(OPCODE_SB, 32'h21, 32'hAAAAAA80); cyc();
    load(OPCODE_LB, 32'h21, 5'd6); cyc();
    chk("lb_sext", o_read_data, 32'hFFFFFF80);
    load(OPCODE_LBU, 32'h21, 5'd6); cyc();
    chk("lbu_zext", o_read_data, 32'h00000080);
    load(OPCODE_LW, 32'h20, 5'd6); cyc();
    chk("sb_word", o_read_data, 32'h11228044);
    load(OPCODE_LB, 32'h23, 5'd6); cyc();
    chk("lb_lane3", o_read_data, 32'h00000011);

    // 3: half store, aligned and misaligned halfword loads
    store(OPCODE_SW, 32'h30, 32'h0); cyc();
    store(OPCODE_SH, 32'h32, 32'hFFFF8001); cyc();
    load(OPCODE_LH, 32'h32, 5'd7); cyc();
    chk("lh_sext", o_read_data, 32'hFFFF8001);
    load(OPCODE_LHU, 32'h32, 5'd7); cyc();
    chk("lhu_zext", o_read_data, 32'h00008001);
    load(OPCODE_LW, 32'h30, 5'd7); cyc();
    chk("sh_word", o_read_data, 32'h80010000);
    load(OPCODE_LH, 32'h33, 5'd7); cyc();
    chk("lh_mis_flag", {31'h0, o_misaligned}, 32'h1);
    chk("lh_mis_rw", {31'h0, o_reg_write}, 32'h0);
    chk("lh_mis_data", o_read_data, 32'h0);

    // 4: misaligned SW suppressed
    store(OPCODE_SW, 32'h40, 32'hCAFEF00D); cyc();
    store(OPCODE_SW, 32'h42, 32'h99999999); cyc();
    chk("sw_mis_flag", {31'h0, o_misaligned}, 32'h1);
    load(OPCODE_LW, 32'h40, 5'd8); cyc();
    chk("sw_mis_kept", o_read_data, 32'hCAFEF00D);
    chk("lw_ok_mis", {31'h0, o_misaligned}, 32'h0);

    // load flagged together with store: store lands, no read data
    nop(); i_opcode = OPCODE_SW; i_mem_read = 1'b1; i_mem_write = 1'b1;
    i_alu_result = 32'h44; i_write_data = 32'h0BADF00D; cyc();
    chk("rdwr_data", o_read_data, 32'h0);
    load(OPCODE_LW, 32'h44, 5'd8); cyc();
    chk("rdwr_stored", o_read_data, 32'h0BADF00D);

    // non-memory op passes through
    nop(); i_opcode = 6'h00; i_alu_result = 32'h00000043; i_reg_write = 1'b1;
    i_write_register = 5'd9; cyc();
    chk("alu_pass", o_alu_result, 32'h43);
    chk("alu_rdata", o_read_data, 32'h0);
    chk("alu_flags", {29'h0, o_reg_write, o_mem_to_reg, o_misaligned}, 32'h4);

    // 5: freeze and mid-stream reset
    store(OPCODE_SW, 32'h50, 32'h01010101); cyc();
    load(OPCODE_LW, 32'h10, 5'd10); cyc();
    store(OPCODE_SW, 32'h50, 32'h77777777);
    i_enable = 1'b0; cyc(); cyc();
    chk("frz_rdata", o_read_data, 32'hDEADBEEF);
    chk("frz_alu", o_alu_result, 32'h10);
    chk("frz_wreg", {27'h0, o_write_register}, 32'd10);
    i_enable = 1'b1;
    load(OPCODE_LW, 32'h50, 5'd11); cyc();
    chk("frz_nowrite", o_read_data, 32'h01010101);
    store(OPCODE_SW, 32'h50, 32'h66666666); i_reg_write = 1'b1; i_write_register = 5'd3;
    reset = 1'b1; cyc();
    chk("mrst_alu", o_alu_result, 32'h0);
    chk("mrst_rdata", o_read_data, 32'h0);
    chk("mrst_misc", {o_write_register, o_reg_write, o_mem_to_reg, o_misaligned}, 8'h0);
    reset = 1'b0;
    load(OPCODE_LW, 32'h50, 5'd12); cyc();
    chk("mrst_ram", o_read_data, 32'h01010101);

    // 6: address wrap and debug port (read-old on collision)
    store(OPCODE_SW, 32'h0, 32'hA5A5A5A5); cyc();
    i_dbg_addr = 8'd0;
    store(OPCODE_SW, 32'h400, 32'h12345678); cyc();
    chk("dbg_old", o_dbg_data, 32'hA5A5A5A5);
    nop(); cyc();
    chk("dbg_new", o_dbg_data, 32'h12345678);
    load(OPCODE_LW, 32'h0, 5'd13); cyc();
    chk("wrap_lw", o_read_data, 32'h12345678);
    i_dbg_addr = 8'd4; i_enable = 1'b0; nop(); cyc();
    chk("dbg_frozen", o_dbg_data, 32'hDEADBEEF);
    i_enable = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
